// File: rtl/uart_tx_fsm.sv
// UART transmit frame sequencer: start, WIDTH data bits, optional parity, stop.
// Define UART_TX_TWO_STOP_EN to append a second stop bit (STOP2) to every frame.
module uart_tx_fsm #(
    parameter int WIDTH = 8
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       Data_Valid,
    input  logic       PAR_EN,
    output logic       load_en,
    output logic       shift_en,
    output logic [1:0] mux_sel,
    output logic       busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        STOP2  = 3'd5
    } state_e;

`ifdef UART_TX_TWO_STOP_EN
    localparam state_e FINAL = STOP2;
`else
    localparam state_e FINAL = STOP;
`endif

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          par_en_q, par_en_d;
    logic          accept;

    // Reset wins over a simultaneous Data_Valid, so the strobe is gated by RST.
    assign accept = RST & Data_Valid & ((state_q == IDLE) | (state_q == FINAL));

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            par_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            par_en_q <= par_en_d;
        end
    end

    always_comb begin
        state_d  = IDLE;
        cnt_d    = cnt_q;
        par_en_d = par_en_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d  = START;
                    par_en_d = PAR_EN;
                end
            end
            START: begin
                state_d = DATA;
                cnt_d   = '0;
            end
            DATA: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = par_en_q ? PARITY : STOP;
                    cnt_d   = '0;
                end else begin
                    state_d = DATA;
                    cnt_d   = cnt_q + CW'(1);
                end
            end
            PARITY: state_d = STOP;
`ifdef UART_TX_TWO_STOP_EN
            STOP: state_d = STOP2;
            STOP2: begin
                if (accept) begin
                    state_d  = START;
                    par_en_d = PAR_EN;
                end
            end
`else
            STOP: begin
                if (accept) begin
                    state_d  = START;
                    par_en_d = PAR_EN;
                end
            end
`endif
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        load_en  = accept;
        mux_sel  = 2'b01;
        shift_en = 1'b0;
        busy     = 1'b0;
        case (state_q)
            START: begin
                mux_sel = 2'b00;
                busy    = 1'b1;
            end
            DATA: begin
                mux_sel  = 2'b10;
                shift_en = 1'b1;
                busy     = 1'b1;
            end
            PARITY: begin
                mux_sel = 2'b11;
                busy    = 1'b1;
            end
            STOP: busy = 1'b1;
`ifdef UART_TX_TWO_STOP_EN
            STOP2: busy = 1'b1;
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_fsm.sv
// Bench for uart_tx_fsm: frame-queue reference model plus directed and random stimulus.
// Compile with UART_TX_TWO_STOP_EN to exercise the two-stop-bit build.
module tb_uart_tx_fsm;

    localparam int WIDTH = 8;
`ifdef UART_TX_TWO_STOP_EN
    localparam int NSTOP = 2;
`else
    localparam int NSTOP = 1;
`endif

    logic       CLK;
    logic       RST;
    logic       Data_Valid;
    logic       PAR_EN;
    logic       load_en;
    logic       shift_en;
    logic [1:0] mux_sel;
    logic       busy;

    uart_tx_fsm #(.WIDTH(WIDTH)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .Data_Valid (Data_Valid),
        .PAR_EN     (PAR_EN),
        .load_en    (load_en),
        .shift_en   (shift_en),
        .mux_sel    (mux_sel),
        .busy       (busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: queue of per-cycle outputs {mux_sel, shift_en, busy} still to
    // come in the current frame, head = this cycle. Empty means idle line.
    logic [3:0] q[$];
    localparam logic [3:0] V_IDLE  = 4'b0100;
    localparam logic [3:0] V_START = 4'b0001;
    localparam logic [3:0] V_DATA  = 4'b1011;
    localparam logic [3:0] V_PAR   = 4'b1101;
    localparam logic [3:0] V_STOP  = 4'b0101;

    function automatic logic model_accept();
        return RST && Data_Valid && (q.size() <= 1);
    endfunction

    always @(posedge CLK) begin
        logic acc;
        logic pe;
        acc = model_accept();
        pe  = PAR_EN;
        if (!RST) begin
            q.delete();
        end else begin
            if (q.size() > 0) void'(q.pop_front());
            if (acc) begin
                q.push_back(V_START);
                for (int i = 0; i < WIDTH; i++) q.push_back(V_DATA);
                if (pe) q.push_back(V_PAR);
                for (int i = 0; i < NSTOP; i++) q.push_back(V_STOP);
            end
        end
    end

    always @(negedge CLK) begin
        logic [3:0] cur;
        cur = (q.size() > 0) ? q[0] : V_IDLE;
        chk("outputs", int'({mux_sel, shift_en, busy}), int'(cur));
        chk("load_en", int'(load_en), int'(model_accept()));
    end

    int busy_n, shift_n, load_n, par_n, gap_n;

    task automatic clr();
        busy_n = 0; shift_n = 0; load_n = 0; par_n = 0; gap_n = 0;
    endtask

    task automatic cyc(input logic dv, input logic pe, input logic rs);
        @(posedge CLK);
        #1;
        Data_Valid = dv;
        PAR_EN     = pe;
        RST        = rs;
        @(negedge CLK);
        busy_n  += int'(busy);
        shift_n += int'(shift_en);
        load_n  += int'(load_en);
        par_n   += int'(mux_sel == 2'b11);
        gap_n   += int'(mux_sel == 2'b01 && !busy);
    endtask

    initial begin
        RST        = 1'b0;
        Data_Valid = 1'b1;
        PAR_EN     = 1'b0;

        // Reset held with Data_Valid asserted
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b1, 1'b0);
            chk("rst_mux", int'(mux_sel), 1);
            chk("rst_busy", int'(busy), 0);
            chk("rst_shift", int'(shift_en), 0);
            chk("rst_load", int'(load_en), 0);
        end
        cyc(1'b0, 1'b0, 1'b1);

        // Single frame, no parity
        clr();
        cyc(1'b1, 1'b0, 1'b1);
        chk("f1_load_now", int'(load_en), 1);
        cyc(1'b0, 1'b0, 1'b1);
        chk("f1_start", int'(mux_sel), 0);
        cyc(1'b0, 1'b0, 1'b1);
        chk("f1_data0", int'(mux_sel), 2);
        for (int i = 0; i < 12; i++) cyc(1'b0, 1'b0, 1'b1);
        chk("f1_busy_len", busy_n, 10 + NSTOP - 1);
        chk("f1_shift_len", shift_n, 8);
        chk("f1_loads", load_n, 1);
        chk("f1_par", par_n, 0);
        chk("f1_idle_end", int'(busy), 0);

        // Parity frame, PAR_EN dropped mid-frame
        clr();
        cyc(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 14; i++) cyc(1'b0, 1'b0, 1'b1);
        chk("f2_busy_len", busy_n, 11 + NSTOP - 1);
        chk("f2_shift_len", shift_n, 8);
        chk("f2_par", par_n, 1);

        // Back-to-back with Data_Valid held high
        clr();
        cyc(1'b1, 1'b0, 1'b1);
        gap_n = 0;
        for (int i = 1; i < 30; i++) cyc(1'b1, 1'b0, 1'b1);
        chk("b2b_loads", load_n, 3);
        chk("b2b_no_gap", gap_n, 0);
        for (int i = 0; i < 14; i++) cyc(1'b0, 1'b0, 1'b1);

        // Data_Valid during DATA and PARITY is ignored
        clr();
        cyc(1'b1, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 1'b1);
        for (int i = 2; i <= 10; i++) cyc(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0, 1'b1);
        chk("ign_loads", load_n, 1);
        chk("ign_busy_len", busy_n, 11 + NSTOP - 1);

        // Reset in the fourth data cycle, then a clean frame
        cyc(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_mux", int'(mux_sel), 1);
        clr();
        cyc(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 12; i++) cyc(1'b0, 1'b0, 1'b1);
        chk("post_rst_busy_len", busy_n, 10 + NSTOP - 1);
        chk("post_rst_shift_len", shift_n, 8);

        // Random traffic against the model
        for (int i = 0; i < 2000; i++) begin
            cyc(logic'($urandom_range(0, 3) == 0),
                logic'($urandom_range(0, 1)),
                logic'($urandom_range(0, 99) != 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
